// File: rtl/alavanca2serial_tx_if.sv
// Lever frame transmitter bus: request, snapshot inputs, UART line and status.
// The DUT side uses slave; the driver side uses master.
interface alavanca2serial_tx_if;
    logic        enviar;
    logic [15:0] al1Bits;
    logic [15:0] al2Bits;
    logic        TX;
    logic        ocupado;
    logic        pronto;
    logic [1:0]  db_estado;
    logic [2:0]  db_byte;

    modport master (
        output enviar, al1Bits, al2Bits,
        input  TX, ocupado, pronto, db_estado, db_byte
    );

    modport slave (
        input  enviar, al1Bits, al2Bits,
        output TX, ocupado, pronto, db_estado, db_byte
    );
endinterface

// File: rtl/alavanca2serial_tx.sv
// Sends "DATA" followed by two 16-bit lever values, LSB first, as 8N1 bytes.
// All outputs are flops; TX idles high.
module alavanca2serial_tx #(
    parameter int BIT_TICKS = 434
) (
    input logic              clock,
    input logic              reset,
    alavanca2serial_tx_if.slave bus
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [15:0]   al1_q, al1_d;
    logic [15:0]   al2_q, al2_d;
    logic          tx_q, tx_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;

    logic [7:0]    cur_byte;
    logic [2:0]    nxt_bit;
    logic          tick_last;

    always_comb begin
        cur_byte = 8'h00;
        unique case (byte_q)
            3'd0: cur_byte = 8'h44;
            3'd1: cur_byte = 8'h41;
            3'd2: cur_byte = 8'h54;
            3'd3: cur_byte = 8'h41;
            3'd4: cur_byte = al1_q[7:0];
            3'd5: cur_byte = al1_q[15:8];
            3'd6: cur_byte = al2_q[7:0];
            3'd7: cur_byte = al2_q[15:8];
            default: cur_byte = 8'h00;
        endcase
    end

    assign nxt_bit   = bit_q + 3'd1;
    assign tick_last = (tick_q == TW'(BIT_TICKS - 1));

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        al1_d     = al1_q;
        al2_d     = al2_q;
        tx_d      = tx_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;

        if (state_q == IDLE) begin
            tx_d      = 1'b1;
            ocupado_d = 1'b0;
            if (bus.enviar && !ocupado_q) begin
                state_d   = START;
                tick_d    = '0;
                bit_d     = 3'd0;
                byte_d    = 3'd0;
                al1_d     = bus.al1Bits;
                al2_d     = bus.al2Bits;
                tx_d      = 1'b0;
                ocupado_d = 1'b1;
            end
        end else if (!tick_last) begin
            tick_d = tick_q + 1'b1;
        end else begin
            // Bit boundary: pick the next line level together with the state.
            tick_d = '0;
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end
                DATA: begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nxt_bit;
                        tx_d  = cur_byte[nxt_bit];
                    end
                end
                STOP: begin
                    if (byte_q == 3'd7) begin
                        state_d   = IDLE;
                        byte_d    = 3'd0;
                        tx_d      = 1'b1;
                        ocupado_d = 1'b0;
                        pronto_d  = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 3'd0;
            al1_q     <= 16'h0000;
            al2_q     <= 16'h0000;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            al1_q     <= al1_d;
            al2_q     <= al2_d;
            tx_q      <= tx_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign bus.TX        = tx_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.pronto    = pronto_q;
    assign bus.db_estado = state_q;
    assign bus.db_byte   = byte_q;

endmodule

// File: doc/alavanca2serial_tx.md
# alavanca2serial_tx

Frame transmitter for the two signed 16-bit lever values, upstream of the lever serial receiver. On request it snapshots `al1Bits`/`al2Bits` and sends one 8-byte 8N1 frame: ASCII preamble "DATA", then each value LSB first. It sits on the sending FPGA and drives the UART line consumed by the receiver stage, which parses exactly this framing.

## Interface
- `BIT_TICKS`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `enviar`  in  1  start request; sampled every edge, level or pulse.
- `al1Bits`  in  16  signed lever 1 value; sampled only on frame start.
- `al2Bits`  in  16  signed lever 2 value; sampled only on frame start.
- `TX`  out  1  UART line; idle high.
- `ocupado`  out  1  high while a frame is on the line.
- `pronto`  out  1  one-cycle pulse at frame completion.
- `db_estado`  out  2  bit-FSM state code (IDLE=0, START=1, DATA=2, STOP=3).
- `db_byte`  out  3  index of the byte being sent (0..7); 0 in IDLE.

## Operation
- Registered outputs only; `TX` is a flop output.
- Reset values: `TX`=1, `ocupado`=0, `pronto`=0, `db_estado`=0, `db_byte`=0. Tick, bit and byte counters cleared; snapshot registers cleared.
- Byte sequence (index 0..7): 0x44, 0x41, 0x54, 0x41, al1[7:0], al1[15:8], al2[7:0], al2[15:8]. Values are sent as raw two's-complement bits; no sign or width conversion.
- Snapshot: both values are latched on the accepting edge. Later input changes do not affect the frame in flight.
- Bit FSM:
  - IDLE: `TX`=1. If `enviar`=1 and `ocupado`=0, go to START with byte 0.
  - START: `TX`=0 for BIT_TICKS cycles, then DATA with bit 0.
  - DATA: `TX`=current byte bit[n], LSB first, BIT_TICKS cycles per bit. After bit 7, go to STOP.
  - STOP: `TX`=1 for BIT_TICKS cycles. Then, if byte < 7, increment the byte index and go to START with no extra idle gap. If byte = 7, go to IDLE.
- Tick counter counts 0..BIT_TICKS-1 and wraps at each bit boundary.
- `enviar` while `ocupado`=1 is ignored; it is not queued.
- Holding `enviar` high gives back-to-back frames separated by exactly one idle clock, with `TX`=1 during that clock.
- Reset mid-frame aborts immediately. `TX`=1 on the next edge, and no `pronto` is produced for the aborted frame.

## Timing
- `enviar` accepted at edge k: after edge k, `TX`=0, `ocupado`=1, `db_estado`=1.
- Bit j of the frame (0..79, where 10 bits per byte) occupies edges k+j·BIT_TICKS through k+(j+1)·BIT_TICKS−1.
- Frame length is exactly 80·BIT_TICKS cycles.
- At edge k+80·BIT_TICKS: `ocupado`=0, `pronto`=1, `db_estado`=0.
- At edge k+80·BIT_TICKS+1: `pronto`=0. This is the earliest edge at which a new `enviar` is accepted.
- `pronto` and `ocupado` are never high together.

## Test plan
- Reset state: assert `reset` 3 cycles -> `TX`=1, `ocupado`=0, `pronto`=0, `db_estado`=0, `db_byte`=0.
- Basic frame (BIT_TICKS=4): al1=16'h1234, al2=16'hFFFE (−2), 1-cycle `enviar`.
  - Line decodes to bytes 44 41 54 41 34 12 FE FF.
  - `ocupado` high for exactly 320 cycles.
  - `pronto` is a single pulse at cycle 320.
- Snapshot / ignore: after the accepting edge, change al1 to 16'h8000 and pulse `enviar` twice mid-frame.
  - The frame still carries 34 12.
  - Only one frame is sent and only one `pronto`.
- Back-to-back: hold `enviar` high for 2 frames with al1=16'h7FFF, al2=16'h8000.
  - Two identical frames are sent: 44 41 54 41 FF 7F 00 80.
  - Exactly one idle-high cycle between them; two `pronto` pulses 321 cycles apart.
- Reset mid-frame: assert `reset` during byte 5, bit 3.
  - `TX`=1 on the next edge; no `pronto`.
  - A subsequent `enviar` sends a complete, correct frame.
- Loopback: connect `TX` to the lever receiver (same BIT_TICKS); send 3 frames (0/0, 100/−100, −32768/32767).
  - Receiver outputs match each pair after the following frame's 'D' byte.
